// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO read engine and its skid buffer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fifo_rd_state_t;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = 2;

  typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/fifo_rd_engine_if.sv
// FIFO read port (active-low rd_n, FWFT empty/dout) plus the outgoing valid/ready stream.
interface fifo_rd_engine_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             rd_n;
  logic             empty;
  logic [WIDTH-1:0] dout;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    output rd_n,
    input  empty,
    input  dout,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  rd_n,
    output empty,
    output dout,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry registered skid buffer; entry 0 is always the head so head_data is a flop output.
module fifo_rd_skid import fifo_rd_pkg::*; #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output occ_t             occ,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  occ_t             occ_q, occ_d, wr_idx;
  logic             do_pop, do_push;

  always_comb begin
    mem_d   = mem_q;
    occ_d   = occ_q;
    do_pop  = pop && (occ_q != '0);
    do_push = push && ((occ_q < occ_t'(BUF_DEPTH)) || do_pop);
    wr_idx  = occ_q - occ_t'(do_pop);
    if (clear) begin
      occ_d = '0;
    end else begin
      if (do_pop) mem_d[0] = mem_q[1];
      if (do_push) begin
        if (wr_idx == '0) mem_d[0] = push_data;
        else              mem_d[1] = push_data;
      end
      occ_d = occ_q + occ_t'(do_push) - occ_t'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      occ_q <= occ_d;
    end
  end

  assign occ        = occ_q;
  assign head_valid = (occ_q != '0);
  assign head_data  = mem_q[0];

endmodule

// File: rtl/fifo_rd_engine.sv
// FIFO read-side master: IDLE/RUN/FLUSH control, rd_n generation, skid-buffered output stream.
// Optional statistics counters are built when FIFO_RD_STATS_EN is defined.
module fifo_rd_engine import fifo_rd_pkg::*; #(
  parameter int unsigned WIDTH = 8
`ifdef FIFO_RD_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  fifo_rd_engine_if.master        bus,
  input  logic                    en,
  input  logic                    flush,
  output logic                    flush_done
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0]        rd_count,
  output logic [CNT_W-1:0]        flush_count
`endif
);

  fifo_rd_state_t   state_q;
  logic             flush_done_q;
  occ_t             occ;
  logic             head_valid;
  logic [WIDTH-1:0] head_data;
  logic             run_pop, flush_pop, buf_clear, xfer;

  // rd_n depends only on registered state/occupancy and the FIFO's registered empty.
  assign run_pop   = (state_q == RUN) && !bus.empty && (occ < occ_t'(BUF_DEPTH));
  assign flush_pop = (state_q == FLUSH) && !bus.empty;
  assign bus.rd_n  = !(run_pop || flush_pop);
  assign buf_clear = flush && (state_q != FLUSH);
  assign xfer      = head_valid && bus.m_ready;

  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (run_pop),
    .push_data  (bus.dout),
    .pop        (xfer),
    .clear      (buf_clear),
    .occ        (occ),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign bus.m_valid = head_valid;
  assign bus.m_data  = head_data;
  assign flush_done  = flush_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flush)   state_q <= FLUSH;
          else if (en) state_q <= RUN;
        end
        RUN: begin
          if (flush)    state_q <= FLUSH;
          else if (!en) state_q <= IDLE;
        end
        FLUSH: begin
          if (bus.empty) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_q + CNT_W'(run_pop);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush_pop);
    end
  end

  assign rd_count    = rd_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule
